// File: rtl/scaler_sfft_framed.sv
// scaler_sfft_framed: framed unary stochastic FFT/IFFT.
//
// A NUMINPUTS-point radix-2 network of uButterfly units, driven by a frame
// controller. Each frame runs the network for 2**SLEN bitstream cycles, shifted
// by PIPE_LAT. During that window it counts ones per output bin.
//
// Ports:
//   iClk, iRst   clock, synchronous active-high reset
//   iStart       frame request (accepted in IDLE, or in DONE with iAck)
//   iInv         0 = FFT, 1 = IFFT, latched at frame start
//   iReal, iImg  bipolar input bitstreams, one bit per point per cycle
//   iAck         consumer accepts the current results
//   oBusy        high in LOADW and RUN
//   oValid       high in DONE
//   oReal, oImg  per-bin ones-counts, bin k at [k*CW +: CW]
//
// This file also holds uButterfly, the bipolar stochastic butterfly used by
// the network.

module uButterfly #(
    parameter int BITWIDTH = 8,   // twiddle weight precision
    parameter int BINPUT   = 2,   // low counter bits skipped by the 1/2-scaling selects
    parameter int STAGE    = 0,
    parameter int NB       = 2,   // butterfly span 2**(STAGE+1)
    parameter int TW       = 0    // twiddle index, W = exp(-j*2*pi*TW/NB)
) (
    input  logic iClk,
    input  logic iRstN,
    input  logic iEn,
    input  logic iClr,
    input  logic loadW,
    input  logic iReal0,
    input  logic iImg0,
    input  logic iReal1,
    input  logic iImg1,
    output logic oReal0,
    output logic oImg0,
    output logic oReal1,
    output logic oImg1
);
    localparam int  CNTW = BITWIDTH + BINPUT;
    localparam real PI   = 3.14159265358979323846;
    localparam real ANG  = 2.0 * PI * $itor(TW) / $itor(NB);
    localparam real WR   = $cos(ANG);
    localparam real WI   = -$sin(ANG);
    localparam real AWR  = (WR < 0.0) ? -WR : WR;
    localparam real AWI  = (WI < 0.0) ? -WI : WI;
    // Probability of taking the W_re term; diagonal twiddles are normalised
    // by |W_re|+|W_im|, trivial ones (1, -j) are exact routing.
    localparam int unsigned THR = $rtoi(AWR / (AWR + AWI) * $itor(2 ** BITWIDTH) + 0.5);
    localparam logic [BITWIDTH:0] THR_W = THR[BITWIDTH:0];
    localparam logic WR_NEG = (WR < -1.0e-9);
    localparam logic WI_NEG = (WI < -1.0e-9);
    localparam logic WI_POS = (WI > 1.0e-9);

    logic [CNTW-1:0]     cnt_q;
    logic [BITWIDTH:0]   thr_q;
    logic [BITWIDTH-1:0] wrev;
    logic                wsel;
    logic                half_sel;
    logic                wb_re;
    logic                wb_im;

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            cnt_q <= '0;
            thr_q <= '0;
        end else begin
            if (loadW) thr_q <= THR_W;
            if (iClr) begin
                cnt_q <= '0;
            end else if (iEn) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Bit-reversed upper counter bits give an evenly spread weight sequence.
    always_comb begin
        wrev = '0;
        for (int i = 0; i < BITWIDTH; i++) begin
            wrev[i] = cnt_q[BINPUT + BITWIDTH - 1 - i];
        end
    end

    assign wsel = ({1'b0, wrev} < thr_q);
    // Each stage uses its own counter bit so the 1/2 mux selects of successive
    // stages average whole periods of the previous stage's outputs.
    assign half_sel = cnt_q[STAGE + BINPUT];

    // W*b: pick the W_re or the W_im product term; bipolar negation is inversion.
    assign wb_re = wsel ? (iReal1 ^ WR_NEG) : (iImg1 ^ WI_POS);
    assign wb_im = wsel ? (iImg1 ^ WR_NEG) : (iReal1 ^ WI_NEG);

    assign oReal0 = half_sel ? iReal0 : wb_re;
    assign oImg0  = half_sel ? iImg0  : wb_im;
    assign oReal1 = half_sel ? iReal0 : ~wb_re;
    assign oImg1  = half_sel ? iImg0  : ~wb_im;
endmodule

module scaler_sfft_framed #(
    parameter int BITWIDTH  = 8,
    parameter int BINPUT    = 2,
    parameter int NUMINPUTS = 8,
    parameter int SLEN      = 8,
    parameter int PIPE_LAT  = 0,
    parameter int LOG2N     = $clog2(NUMINPUTS),
    parameter int CW        = SLEN + 1
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iStart,
    input  logic                    iInv,
    input  logic [NUMINPUTS-1:0]    iReal,
    input  logic [NUMINPUTS-1:0]    iImg,
    input  logic                    iAck,
    output logic                    oBusy,
    output logic                    oValid,
    output logic [NUMINPUTS*CW-1:0] oReal,
    output logic [NUMINPUTS*CW-1:0] oImg
);
    localparam int unsigned LEN    = 2 ** SLEN;
    localparam int unsigned RUNLEN = LEN + PIPE_LAT;
    localparam int          CYCW   = $clog2(RUNLEN + 1);
    localparam logic [CYCW-1:0] CYC_LAST = CYCW'(RUNLEN - 1);

    typedef enum logic [1:0] {StIdle, StLoadW, StRun, StDone} state_e;

    state_e          state_q;
    logic            inv_q;
    logic            busy_q;
    logic            valid_q;
    logic [CYCW-1:0] cyc_q;
    logic [CW-1:0]   cnt_re_q [NUMINPUTS];
    logic [CW-1:0]   cnt_im_q [NUMINPUTS];

    logic                 rst_n;
    logic                 bf_en;
    logic                 bf_clr;
    logic                 count_en;
    logic [NUMINPUTS-1:0] net_in_re;
    logic [NUMINPUTS-1:0] net_in_im;
    logic [NUMINPUTS-1:0] fin_re;
    logic [NUMINPUTS-1:0] fin_im;
    logic [NUMINPUTS-1:0] cnt_in_re;
    logic [NUMINPUTS-1:0] cnt_in_im;

    function automatic int bitrev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < LOG2N; b++) begin
            if (v[b]) r = r | (1 << (LOG2N - 1 - b));
        end
        return r;
    endfunction

    assign rst_n  = ~iRst;
    assign bf_en  = (state_q == StRun);
    assign bf_clr = (state_q == StLoadW);

    // Decimation-in-time network: bit-reversed feed gives natural-order bins.
    // Conjugating input and output imag turns the FFT into the IFFT.
    for (genvar k = 0; k < NUMINPUTS; k++) begin : g_feed
        assign net_in_re[k] = iReal[bitrev(k)];
        assign net_in_im[k] = iImg[bitrev(k)] ^ inv_q;
    end

    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        localparam int B = 2 ** (s + 1);
        logic [NUMINPUTS-1:0] in_re;
        logic [NUMINPUTS-1:0] in_im;
        logic [NUMINPUTS-1:0] out_re;
        logic [NUMINPUTS-1:0] out_im;

        if (s == 0) begin : g_first
            assign in_re = net_in_re;
            assign in_im = net_in_im;
        end else begin : g_next
            assign in_re = g_stage[s-1].out_re;
            assign in_im = g_stage[s-1].out_im;
        end

        for (genvar i = 0; i < NUMINPUTS; i = i + B) begin : g_grp
            for (genvar j = 0; j < B / 2; j++) begin : g_bf
                uButterfly #(
                    .BITWIDTH(BITWIDTH),
                    .BINPUT  (BINPUT),
                    .STAGE   (s),
                    .NB      (B),
                    .TW      (j)
                ) u_bf (
                    .iClk  (iClk),
                    .iRstN (rst_n),
                    .iEn   (bf_en),
                    .iClr  (bf_clr),
                    .loadW (bf_clr),
                    .iReal0(in_re[i+j]),
                    .iImg0 (in_im[i+j]),
                    .iReal1(in_re[i+j+B/2]),
                    .iImg1 (in_im[i+j+B/2]),
                    .oReal0(out_re[i+j]),
                    .oImg0 (out_im[i+j]),
                    .oReal1(out_re[i+j+B/2]),
                    .oImg1 (out_im[i+j+B/2])
                );
            end
        end
    end

    assign fin_re = g_stage[LOG2N-1].out_re;
    assign fin_im = g_stage[LOG2N-1].out_im ^ {NUMINPUTS{inv_q}};

    // Models the network's register delay; counting skips the first PIPE_LAT cycles.
    if (PIPE_LAT == 0) begin : g_nodly
        assign cnt_in_re = fin_re;
        assign cnt_in_im = fin_im;
        assign count_en  = 1'b1;
    end else begin : g_dly
        logic [NUMINPUTS-1:0] dly_re [PIPE_LAT];
        logic [NUMINPUTS-1:0] dly_im [PIPE_LAT];

        always_ff @(posedge iClk) begin
            if (iRst) begin
                for (int i = 0; i < PIPE_LAT; i++) begin
                    dly_re[i] <= '0;
                    dly_im[i] <= '0;
                end
            end else begin
                dly_re[0] <= fin_re;
                dly_im[0] <= fin_im;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    dly_re[i] <= dly_re[i-1];
                    dly_im[i] <= dly_im[i-1];
                end
            end
        end

        assign cnt_in_re = dly_re[PIPE_LAT-1];
        assign cnt_in_im = dly_im[PIPE_LAT-1];
        assign count_en  = (cyc_q >= CYCW'(PIPE_LAT));
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= StIdle;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cyc_q   <= '0;
            for (int k = 0; k < NUMINPUTS; k++) begin
                cnt_re_q[k] <= '0;
                cnt_im_q[k] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (iStart) begin
                        inv_q   <= iInv;
                        busy_q  <= 1'b1;
                        state_q <= StLoadW;
                    end
                end
                StLoadW: begin
                    cyc_q <= '0;
                    for (int k = 0; k < NUMINPUTS; k++) begin
                        cnt_re_q[k] <= '0;
                        cnt_im_q[k] <= '0;
                    end
                    state_q <= StRun;
                end
                StRun: begin
                    for (int k = 0; k < NUMINPUTS; k++) begin
                        if (count_en && cnt_in_re[k]) cnt_re_q[k] <= cnt_re_q[k] + CW'(1);
                        if (count_en && cnt_in_im[k]) cnt_im_q[k] <= cnt_im_q[k] + CW'(1);
                    end
                    cyc_q <= cyc_q + 1'b1;
                    if (cyc_q == CYC_LAST) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (iAck) begin
                        valid_q <= 1'b0;
                        if (iStart) begin
                            // Back-to-back frame without an IDLE cycle.
                            inv_q   <= iInv;
                            busy_q  <= 1'b1;
                            state_q <= StLoadW;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign oBusy  = busy_q;
    assign oValid = valid_q;

    for (genvar k = 0; k < NUMINPUTS; k++) begin : g_out
        assign oReal[k*CW +: CW] = cnt_re_q[k];
        assign oImg[k*CW +: CW]  = cnt_im_q[k];
    end
endmodule
